// File: rtl/tristate_bus_pkg.sv
// Shared types and defaults for the arbitrated tristate bus driver.
// Holds the FSM state type, default parameters and a counter-width helper.
package tristate_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_NSRC     = 4;
   localparam int DEF_MAXBURST = 4;
   localparam int DEF_TURN     = 1;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tristate_bus_ctrl_if.sv
// Request/grant handshake between the sources and the bus controller.
// The shared data bus itself stays a plain inout on the controller.
interface tristate_bus_ctrl_if
   import tristate_bus_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NSRC  = DEF_NSRC
);
   logic [NSRC-1:0]       req;
   logic [NSRC*WIDTH-1:0] din;
   logic [NSRC-1:0]       gnt;
   logic [NSRC-1:0]       ack;
   logic                  oe_n;

   modport master (output req, output din, input gnt, input ack, input oe_n);
   modport slave  (input req, input din, output gnt, output ack, output oe_n);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
// Also returns the winner index and the pointer value that follows it.
module rr_arbiter
   import tristate_bus_pkg::*;
#(
   parameter int NSRC = DEF_NSRC,
   localparam int PW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic [NSRC-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NSRC-1:0] o_gnt,
   output logic [PW-1:0]   o_idx,
   output logic [PW-1:0]   o_next_ptr
);
   logic          w_found;
   logic [PW-1:0] w_pos;

   always_comb begin
      o_gnt      = '0;
      o_idx      = '0;
      o_next_ptr = '0;
      w_found    = 1'b0;
      w_pos      = '0;
      for (int k = 0; k < NSRC; k++) begin
         w_pos = PW'((int'(i_ptr) + k) % NSRC);
         if (!w_found && i_req[w_pos]) begin
            w_found       = 1'b1;
            o_gnt[w_pos]  = 1'b1;
            o_idx         = w_pos;
            o_next_ptr    = PW'((int'(w_pos) + 1) % NSRC);
         end
      end
   end

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Arbitrated tristate bus driver: round-robin grants, capped bursts,
// registered bus data and guaranteed idle turnaround between owners.
module tristate_bus_ctrl
   import tristate_bus_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NSRC     = DEF_NSRC,
   parameter int MAXBURST = DEF_MAXBURST,
   parameter int TURN     = DEF_TURN
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   tristate_bus_ctrl_if.slave if_bus,
   inout  wire  [WIDTH-1:0]   io_bus
);
   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int CW = cnt_width(MAXBURST);
   localparam int TW = cnt_width(TURN);

   state_t           r_state, w_state_nxt;
   logic [NSRC-1:0]  r_gnt, w_gnt_nxt;
   logic [PW-1:0]    r_ptr, w_ptr_nxt;
   logic [PW-1:0]    r_own, w_own_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [TW-1:0]    r_tcnt, w_tcnt_nxt;
   logic [WIDTH-1:0] r_data;
   logic             r_oe_n;

   logic [NSRC-1:0]  w_ack;
   logic             w_ack_any;
   logic [NSRC-1:0]  w_arb_gnt;
   logic [PW-1:0]    w_arb_idx;
   logic [PW-1:0]    w_arb_next_ptr;
   logic [WIDTH-1:0] w_din_sel;

   rr_arbiter #(.NSRC(NSRC)) u_arb (
      .i_req      (if_bus.req),
      .i_ptr      (r_ptr),
      .o_gnt      (w_arb_gnt),
      .o_idx      (w_arb_idx),
      .o_next_ptr (w_arb_next_ptr)
   );

   assign w_ack     = r_gnt & if_bus.req & {NSRC{r_state == ST_OWN}};
   assign w_ack_any = |w_ack;
   assign w_din_sel = WIDTH'(if_bus.din >> (int'(r_own) * WIDTH));

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ptr_nxt   = r_ptr;
      w_own_nxt   = r_own;
      w_cnt_nxt   = r_cnt;
      w_tcnt_nxt  = r_tcnt;
      case (r_state)
         ST_IDLE: begin
            if (|if_bus.req) begin
               w_gnt_nxt   = w_arb_gnt;
               w_own_nxt   = w_arb_idx;
               w_ptr_nxt   = w_arb_next_ptr;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_OWN;
            end
         end
         ST_OWN: begin
            if (w_ack_any) w_cnt_nxt = r_cnt + 1'b1;
            // Owner dropped its request, or this word completes the burst.
            if (!w_ack_any || r_cnt == CW'(MAXBURST - 1)) begin
               w_gnt_nxt   = '0;
               w_tcnt_nxt  = '0;
               w_state_nxt = ST_TURN;
            end
         end
         ST_TURN: begin
            if (r_tcnt == TW'(TURN)) w_state_nxt = ST_IDLE;
            else                     w_tcnt_nxt  = r_tcnt + 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_own   <= '0;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         // NOTE: the data register is a single word, not a memory, so it is
         // reset to a known value along with the control state.
         r_data  <= '0;
         r_oe_n  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_own   <= w_own_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_oe_n  <= !w_ack_any;
         if (w_ack_any) r_data <= w_din_sel;
      end
   end

   assign if_bus.gnt  = r_gnt;
   assign if_bus.ack  = w_ack;
   assign if_bus.oe_n = r_oe_n;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bus_drv
      bufif0 u_drv (io_bus[g], r_data[g], r_oe_n);
   end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Self-checking bench for tristate_bus_ctrl: directed vectors, corner
// sequences, a TURN=3/NSRC=2 build and random traffic against a model.
module tb_tristate_bus_ctrl;
   import tristate_bus_pkg::*;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int MB  = 4;
   localparam int TT  = 1;
   localparam int N2  = 2;
   localparam int TT2 = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tristate_bus_ctrl_if #(.WIDTH(W), .NSRC(N))  bif ();
   tristate_bus_ctrl_if #(.WIDTH(W), .NSRC(N2)) bif2 ();
   wire [W-1:0] bus;
   wire [W-1:0] bus2;

   logic [W-1:0] din_arr  [N];
   logic [W-1:0] din2_arr [N2];

   always_comb begin
      for (int s = 0; s < N; s++)  bif.din[s*W +: W]  = din_arr[s];
      for (int s = 0; s < N2; s++) bif2.din[s*W +: W] = din2_arr[s];
   end

   tristate_bus_ctrl #(.WIDTH(W), .NSRC(N), .MAXBURST(MB), .TURN(TT)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .if_bus(bif), .io_bus(bus)
   );

   tristate_bus_ctrl #(.WIDTH(W), .NSRC(N2), .MAXBURST(MB), .TURN(TT2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .if_bus(bif2), .io_bus(bus2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [W-1:0] din2;
      logic [N-1:0] gnt;
      logic [N-1:0] ack;
      logic         oe_n;
      logic         chk_bus;
      logic [W-1:0] bus;
   } vec_t;

   vec_t vecs [8];

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) return i;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n    = 1'b0;
      bif.req  = '0;
      bif2.req = '0;
      for (int s = 0; s < N; s++)  din_arr[s]  = '0;
      for (int s = 0; s < N2; s++) din2_arr[s] = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference-model state for the random phase.
   int           m_owner, m_words, m_cool, m_ptr;
   bit           m_prev_ack;
   logic [W-1:0] m_prev_word;

   initial begin
      int           ack_at[$];
      int           owners[$];
      int           words[$];
      int           gap;
      bit           seen_low;
      bit           prev_ack1;
      logic [N-1:0] prev_gnt;
      logic [N2-1:0] prev_gnt2;
      int           prev_own2;
      int           grants2;
      logic [N-1:0] exp_gnt, exp_ack;

      vecs[0] = '{4'b0100, 16'hA5A0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000};
      vecs[1] = '{4'b0100, 16'hA5A0, 4'b0100, 4'b0100, 1'b1, 1'b0, 16'h0000};
      vecs[2] = '{4'b0100, 16'hA5A1, 4'b0100, 4'b0100, 1'b0, 1'b1, 16'hA5A0};
      vecs[3] = '{4'b0100, 16'hA5A2, 4'b0100, 4'b0100, 1'b0, 1'b1, 16'hA5A1};
      vecs[4] = '{4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 16'hA5A2};
      vecs[5] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000};
      vecs[6] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000};
      vecs[7] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000};

      // Reset values, then quiet bus with no requests.
      rst_n   = 1'b0;
      bif.req = '0;
      bif2.req = '0;
      for (int s = 0; s < N; s++)  din_arr[s]  = '0;
      for (int s = 0; s < N2; s++) din2_arr[s] = '0;
      @(negedge clk);
      check("rst_oe_n", bif.oe_n, 1'b1);
      check("rst_gnt", bif.gnt, 4'b0000);
      check("rst_ack", bif.ack, 4'b0000);
      end_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("idle_oe_n", bif.oe_n, 1'b1);
         check("idle_gnt", bif.gnt, 4'b0000);
         end_cycle();
      end

      // Single three-word burst from source 2.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bif.req    = vecs[i].req;
         din_arr[2] = vecs[i].din2;
         @(negedge clk);
         check("vec_gnt", bif.gnt, vecs[i].gnt);
         check("vec_ack", bif.ack, vecs[i].ack);
         check("vec_oe_n", bif.oe_n, vecs[i].oe_n);
         if (vecs[i].chk_bus) check("vec_bus", bus, vecs[i].bus);
         end_cycle();
      end

      // Burst cap and re-grant of a lone requester.
      do_reset();
      bif.req   = 4'b0010;
      prev_ack1 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         din_arr[1] = W'(16'h1100 + c);
         @(negedge clk);
         if (prev_ack1) check("cap_bus_word", bus, W'(16'h1100 + c - 1));
         prev_ack1 = bif.ack[1];
         if (bif.ack[1]) ack_at.push_back(c);
         end_cycle();
      end
      bif.req = '0;
      check("cap_ack_count", ack_at.size(), 8);
      if (ack_at.size() == 8) begin
         check("cap_first_ack", ack_at[0], 1);
         check("cap_fourth_ack", ack_at[3], 4);
         check("cap_regrant_ack", ack_at[4], 8);
         check("cap_last_ack", ack_at[7], 11);
      end
      repeat (4) end_cycle();

      // Round robin with every source requesting.
      do_reset();
      bif.req  = 4'b1111;
      prev_gnt = '0;
      gap      = 0;
      seen_low = 1'b0;
      for (int c = 0; c < 40; c++) begin
         for (int s = 0; s < N; s++) din_arr[s] = W'($urandom);
         @(negedge clk);
         check("rr_onehot", $onehot0(bif.gnt), 1'b1);
         if (bif.gnt != '0 && prev_gnt == '0) begin
            owners.push_back(onehot_idx(bif.gnt));
            words.push_back(0);
         end
         if (bif.ack != '0 && words.size() > 0) words[words.size()-1] += 1;
         if (!bif.oe_n) begin
            if (seen_low && gap > 0) check("rr_turn_gap", gap >= TT + 1, 1'b1);
            gap      = 0;
            seen_low = 1'b1;
         end else if (seen_low) gap++;
         prev_gnt = bif.gnt;
         end_cycle();
      end
      bif.req = '0;
      check("rr_grant_count", owners.size() >= 5, 1'b1);
      for (int i = 0; i < 5 && i < owners.size(); i++) check("rr_order", owners[i], i % N);
      for (int i = 0; i < 4 && i < words.size(); i++) check("rr_words", words[i], MB);

      // Asynchronous reset while source 3's second word is on the bus.
      do_reset();
      bif.req    = 4'b1000;
      din_arr[3] = 16'h3300;
      end_cycle();
      @(negedge clk);
      check("ar_ack_w1", bif.ack, 4'b1000);
      end_cycle();
      din_arr[3] = 16'h3301;
      end_cycle();
      check("ar_oe_low", bif.oe_n, 1'b0);
      check("ar_bus_w2", bus, 16'h3301);
      #2 rst_n = 1'b0;
      #1;
      check("ar_oe_n_async", bif.oe_n, 1'b1);
      check("ar_gnt_async", bif.gnt, 4'b0000);
      check("ar_ack_async", bif.ack, 4'b0000);
      bif.req = 4'b1001;
      rst_n   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ar_regrant_src0", bif.gnt, 4'b0001);
      end_cycle();
      bif.req = '0;
      repeat (8) end_cycle();

      // Two-source build with a longer turnaround.
      do_reset();
      bif2.req  = 2'b11;
      prev_gnt2 = '0;
      prev_own2 = -1;
      grants2   = 0;
      gap       = 0;
      seen_low  = 1'b0;
      for (int c = 0; c < 60; c++) begin
         for (int s = 0; s < N2; s++) din2_arr[s] = W'($urandom);
         @(negedge clk);
         if (!bif2.oe_n) begin
            check("t3_bus_known", $isunknown(bus2), 1'b0);
            if (seen_low && gap > 0) check("t3_turn_gap", gap >= TT2 + 1, 1'b1);
            gap      = 0;
            seen_low = 1'b1;
         end else if (seen_low) gap++;
         if (bif2.gnt != '0 && prev_gnt2 == '0) begin
            if (prev_own2 >= 0) check("t3_alternate", (bif2.gnt == 2'b01) ? 0 : 1, 1 - prev_own2);
            prev_own2 = (bif2.gnt == 2'b01) ? 0 : 1;
            grants2++;
         end
         prev_gnt2 = bif2.gnt;
         end_cycle();
      end
      bif2.req = '0;
      check("t3_grants", grants2 >= 4, 1'b1);

      // Random traffic against the transaction-level model.
      do_reset();
      m_owner     = -1;
      m_words     = 0;
      m_cool      = 0;
      m_ptr       = 0;
      m_prev_ack  = 1'b0;
      m_prev_word = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) bif.req = N'($urandom_range(0, 15));
         for (int s = 0; s < N; s++) din_arr[s] = W'($urandom);
         @(negedge clk);
         exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         exp_ack = ((bif.req & exp_gnt) != '0) ? exp_gnt : '0;
         check("rnd_gnt", bif.gnt, exp_gnt);
         check("rnd_ack", bif.ack, exp_ack);
         check("rnd_oe_n", bif.oe_n, !m_prev_ack);
         if (m_prev_ack) check("rnd_bus", bus, m_prev_word);
         if (exp_ack != '0) begin
            m_prev_word = din_arr[m_owner];
            m_words++;
         end
         m_prev_ack = (exp_ack != '0);
         if (m_owner >= 0) begin
            if (exp_ack == '0 || m_words == MB) begin
               m_owner = -1;
               m_cool  = TT + 1;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (bif.req != '0) begin
            for (int k = 0; k < N; k++) begin
               if (m_owner < 0 && ((bif.req >> ((m_ptr + k) % N)) & N'(1)) != '0) begin
                  m_owner = (m_ptr + k) % N;
               end
            end
            m_ptr   = (m_owner + 1) % N;
            m_words = 0;
         end
         end_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
